riscv_pipe_skid_reg: RTL

Parametrised pipeline stage register with valid/ready handshake, two-entry skid buffer and synchronous flush. It is the generic successor to the fixed-field stage registers between IF/ID/EX/MEM/WB. It lets any stage boundary carry an arbitrary packed payload, absorb one beat of downstream back-pressure without a combinational ready path, and drop in-flight instructions on a branch or exception flush.

---
 rtl/riscv_pipe_skid_reg_pkg.sv | 34 +++
 rtl/riscv_pipe_skid_reg_sat_counter.sv | 31 +++
 rtl/riscv_pipe_skid_reg.sv | 100 ++++++++++
 3 files changed

// File: rtl/riscv_pipe_skid_reg_pkg.sv
// Shared definitions for the pipeline skid register: XLEN, the default stage payload layout and the FSM encoding.
// The optional stall counter is enabled by defining PIPE_STALL_CNT_EN.
package riscv_pipe_skid_reg_pkg;

  localparam int XLEN        = 32;
  localparam int WREG_W      = 5;
  localparam int PIPE_DATA_W = 2 * XLEN + 7;
  localparam int PIPE_CNT_W  = 32;

  // Default MEM/WB-style payload layout, LSB first, so every stage packs and unpacks the same way.
  localparam int OFF_RDATA    = 0;
  localparam int OFF_ALU      = XLEN;
  localparam int OFF_WREG     = 2 * XLEN;
  localparam int OFF_MEMTOREG = 2 * XLEN + WREG_W;
  localparam int OFF_REGWRITE = 2 * XLEN + WREG_W + 1;

  // Encoding is {main_valid, skid_valid}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } skid_state_e;

  function automatic logic [PIPE_DATA_W-1:0] pack_stage(
    input logic [XLEN-1:0]   rdata,
    input logic [XLEN-1:0]   alu,
    input logic [WREG_W-1:0] wreg,
    input logic              memtoreg,
    input logic              regwrite
  );
    return {regwrite, memtoreg, wreg, alu, rdata};
  endfunction

endpackage

// File: rtl/riscv_pipe_skid_reg_sat_counter.sv
// Saturating up-counter; holds at all-ones and clears only on reset.
module riscv_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/riscv_pipe_skid_reg.sv
// Pipeline stage register with a two-entry skid buffer, registered in_ready and synchronous flush.
// Define PIPE_STALL_CNT_EN to add the saturating stall_count output.
module riscv_pipe_skid_reg
  import riscv_pipe_skid_reg_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CNT_W  = PIPE_CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_count
`endif
);

  skid_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_xfer;
  logic              out_xfer;

  if (DATA_W < 1 || CNT_W < 1) begin : g_param_check
    $error("riscv_pipe_skid_reg: DATA_W and CNT_W must be positive");
  end

  // Both handshake qualifiers come straight from flops, so no ready path crosses the stage.
  assign in_ready  = ~state_q[0];
  assign out_valid = state_q[1];
  assign out_data  = main_data_q;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_data_d = in_data;
            state_d     = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            main_data_d = in_data;
          end else if (in_xfer) begin
            skid_data_d = in_data;
            state_d     = ST_FULL;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_xfer) begin
            main_data_d = skid_data_q;
            state_d     = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
    end
  end

`ifdef PIPE_STALL_CNT_EN
  riscv_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (out_valid & ~out_ready),
    .count (stall_count)
  );
`else
`endif

endmodule
